fetch_sched: RTL and testbench

Round-robin scheduler that shares the single `FETCH` unit among the CPU's four hardware threads. Each thread presents an independent read/write request. The scheduler grants one thread at a time, drives `FETCH`'s request port (`f_enable`, `write_mode`, `addr`, `data_i`, `thread`) and waits for its `ack`. It then returns read data and a one-cycle completion or error pulse to the owning thread. It sits between the per-thread pipeline front ends and `FETCH`; the `FETCH` bus-side (`W_*`) ports are untouched.

---
 rtl/fetch_sched_pkg.sv | 24 ++
 rtl/fetch_sched_if.sv | 32 +++
 rtl/fetch_sched_rr_pick4.sv | 24 ++
 rtl/fetch_sched.sv | 103 ++++++++++
 tb/tb_fetch_sched.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sched_pkg.sv
// Shared definitions for the fetch scheduler: thread count, state encoding
// and the default FETCH timeout.
package fetch_sched_pkg;

  localparam int NTHREADS      = 4;
  localparam int THREAD_W      = 2;
  localparam int DATA_W        = 32;
  localparam int CNT_W         = 8;
  localparam int FETCH_TIMEOUT = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_BUSY = 2'd1,
    FS_RESP = 2'd2
  } fs_state_e;

  typedef logic [THREAD_W-1:0] thread_t;
  typedef logic [NTHREADS-1:0] tmask_t;

  function automatic tmask_t thread_onehot(thread_t t);
    return tmask_t'(1) << t;
  endfunction

endpackage

// File: rtl/fetch_sched_if.sv
// Bundle of the per-thread request/response port and the FETCH request port.
// master is the scheduler's view; slave is the front ends plus FETCH.
interface fetch_sched_if;
  import fetch_sched_pkg::*;

  logic [NTHREADS-1:0]        t_req;
  logic [NTHREADS-1:0]        t_write;
  logic [NTHREADS*DATA_W-1:0] t_addr;
  logic [NTHREADS*DATA_W-1:0] t_wdata;
  logic [NTHREADS-1:0]        t_ack;
  logic [NTHREADS-1:0]        t_err;
  logic [DATA_W-1:0]          t_rdata;

  logic                       f_enable;
  logic                       f_write;
  logic [DATA_W-1:0]          f_addr;
  logic [DATA_W-1:0]          f_wdata;
  logic [THREAD_W-1:0]        f_thread;
  logic [DATA_W-1:0]          f_rdata;
  logic                       f_ack;

  modport master (
    input  t_req, t_write, t_addr, t_wdata, f_rdata, f_ack,
    output t_ack, t_err, t_rdata, f_enable, f_write, f_addr, f_wdata, f_thread
  );

  modport slave (
    output t_req, t_write, t_addr, t_wdata, f_rdata, f_ack,
    input  t_ack, t_err, t_rdata, f_enable, f_write, f_addr, f_wdata, f_thread
  );

endinterface

// File: rtl/fetch_sched_rr_pick4.sv
// Combinational 4-way round-robin picker: first set request bit after 'last',
// scanning upward modulo 4. Shared with the writeback arbiter.
module rr_pick4
  import fetch_sched_pkg::*;
(
  input  logic [NTHREADS-1:0] req,
  input  thread_t             last,
  output thread_t             grant,
  output logic                valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant = last;
    valid = 1'b0;
    for (int i = 1; i <= NTHREADS; i++) begin
      if (!valid && req[last + thread_t'(i)]) begin
        grant = last + thread_t'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_sched.sv
// Shares the single FETCH unit among four hardware threads: round-robin grant,
// one outstanding FETCH request, ack/timeout pulse back to the owning thread.
module fetch_sched
  import fetch_sched_pkg::*;
#(
  parameter int TIMEOUT = FETCH_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  fetch_sched_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fs_state_e         state_q;
  thread_t           last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              f_enable_q;
  logic              f_write_q;
  logic [DATA_W-1:0] f_addr_q;
  logic [DATA_W-1:0] f_wdata_q;
  thread_t           f_thread_q;
  tmask_t            t_ack_q;
  tmask_t            t_err_q;
  logic [DATA_W-1:0] t_rdata_q;

  thread_t           pick_grant;
  logic              pick_valid;

  rr_pick4 u_pick (
    .req   (bus.t_req),
    .last  (last_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // NOTE: all state below is sequential, so it is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      last_q     <= thread_t'(NTHREADS - 1);
      cnt_q      <= '0;
      f_enable_q <= 1'b0;
      f_write_q  <= 1'b0;
      f_addr_q   <= '0;
      f_wdata_q  <= '0;
      f_thread_q <= '0;
      t_ack_q    <= '0;
      t_err_q    <= '0;
      t_rdata_q  <= '0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (pick_valid) begin
            f_write_q  <= bus.t_write[pick_grant];
            f_addr_q   <= bus.t_addr[DATA_W*pick_grant +: DATA_W];
            f_wdata_q  <= bus.t_wdata[DATA_W*pick_grant +: DATA_W];
            f_thread_q <= pick_grant;
            last_q     <= pick_grant;
            cnt_q      <= '0;
            f_enable_q <= 1'b1;
            state_q    <= FS_BUSY;
          end
        end

        FS_BUSY: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (bus.f_ack) begin
            t_rdata_q  <= bus.f_rdata;
            t_ack_q    <= thread_onehot(f_thread_q);
            f_enable_q <= 1'b0;
            state_q    <= FS_RESP;
          end else if (cnt_q == CNT_LAST) begin
            t_err_q    <= thread_onehot(f_thread_q);
            f_enable_q <= 1'b0;
            state_q    <= FS_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        FS_RESP: begin
          // No arbitration here: gives the finished thread one edge to drop its request.
          t_ack_q <= '0;
          t_err_q <= '0;
          state_q <= FS_IDLE;
        end

        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign bus.f_enable = f_enable_q;
  assign bus.f_write  = f_write_q;
  assign bus.f_addr   = f_addr_q;
  assign bus.f_wdata  = f_wdata_q;
  assign bus.f_thread = f_thread_q;
  assign bus.t_ack    = t_ack_q;
  assign bus.t_err    = t_err_q;
  assign bus.t_rdata  = t_rdata_q;

endmodule

// File: tb/tb_fetch_sched.sv
// Scoreboard bench for fetch_sched: thread front ends and a FETCH responder
// are modelled in one process; expected grants and responses are queued up front.
module tb_fetch_sched;
  import fetch_sched_pkg::*;

  localparam int TMO = 16;

  typedef struct packed {
    logic [1:0]  thr;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  gap;
  } req_exp_t;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_sched_if bus ();

  fetch_sched #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  req_exp_t cur;

  int          pend[4];
  logic        th_wr[4];
  logic [31:0] th_addr[4];
  logic [31:0] th_wdata[4];
  logic [31:0] rd_val[4];
  int          ack_delay = 1;
  int          busy_cnt  = 0;
  logic        late_ack  = 1'b0;
  logic        prev_en   = 1'b0;
  int          cyc       = 0;
  int          rise_cyc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_thread(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    th_wr[i]    = wr;
    th_addr[i]  = a;
    th_wdata[i] = d;
    bus.t_write[i]          = wr;
    bus.t_addr[32*i +: 32]  = a;
    bus.t_wdata[32*i +: 32] = d;
  endtask

  task automatic push_req(input int thr, input int gap);
    req_exp_t e;
    e.thr   = 2'(thr);
    e.wr    = th_wr[thr];
    e.addr  = th_addr[thr];
    e.wdata = th_wdata[thr];
    e.gap   = 8'(gap);
    req_q.push_back(e);
  endtask

  task automatic push_ack(input int thr, input int lat);
    rsp_exp_t e;
    e.ack   = 4'b0001 << thr;
    e.err   = 4'b0000;
    e.rdata = rd_val[thr];
    e.lat   = 8'(lat);
    rsp_q.push_back(e);
  endtask

  task automatic push_err(input int thr, input int lat);
    rsp_exp_t e;
    e.ack   = 4'b0000;
    e.err   = 4'b0001 << thr;
    e.rdata = '0;
    e.lat   = 8'(lat);
    rsp_q.push_back(e);
  endtask

  task automatic monitor();
    logic [3:0] pulse;
    rsp_exp_t   r;
    pulse = bus.t_ack | bus.t_err;
    if (bus.f_enable && !prev_en) begin
      if (req_q.size() == 0) begin
        check("unexpected_grant", 32'(bus.f_thread), 32'hFFFF_FFFF);
      end else begin
        cur = req_q.pop_front();
        check("grant_thread", 32'(bus.f_thread), 32'(cur.thr));
        check("grant_write", 32'(bus.f_write), 32'(cur.wr));
        check("grant_addr", bus.f_addr, cur.addr);
        check("grant_wdata", bus.f_wdata, cur.wdata);
        if (cur.gap != 0) check("grant_gap", 32'(cyc - rise_cyc), 32'(cur.gap));
      end
      rise_cyc = cyc;
    end else if (bus.f_enable) begin
      check("busy_thread_stable", 32'(bus.f_thread), 32'(cur.thr));
      check("busy_write_stable", 32'(bus.f_write), 32'(cur.wr));
      check("busy_addr_stable", bus.f_addr, cur.addr);
      check("busy_wdata_stable", bus.f_wdata, cur.wdata);
    end
    if (pulse != 4'b0000) begin
      check("done_onehot", 32'($countones(pulse) <= 1), 32'd1);
      check("done_f_enable_low", 32'(bus.f_enable), 32'd0);
      if (rsp_q.size() == 0) begin
        check("unexpected_done", 32'(pulse), 32'd0);
      end else begin
        r = rsp_q.pop_front();
        check("done_t_ack", 32'(bus.t_ack), 32'(r.ack));
        check("done_t_err", 32'(bus.t_err), 32'(r.err));
        if (r.ack != 4'b0000) check("done_t_rdata", bus.t_rdata, r.rdata);
        check("done_latency", 32'(cyc - rise_cyc), 32'(r.lat));
      end
    end
    prev_en = bus.f_enable;
  endtask

  // Thread front ends (hold t_req until done) and the FETCH responder.
  task automatic model();
    for (int i = 0; i < 4; i++) begin
      if ((bus.t_ack[i] || bus.t_err[i]) && pend[i] > 0) pend[i]--;
      bus.t_req[i] = (pend[i] > 0);
    end
    if (bus.f_enable) begin
      busy_cnt++;
      if (ack_delay > 0 && busy_cnt == ack_delay) begin
        bus.f_ack   = 1'b1;
        bus.f_rdata = rd_val[bus.f_thread];
      end else begin
        bus.f_ack   = 1'b0;
        bus.f_rdata = $urandom;
      end
    end else begin
      busy_cnt    = 0;
      bus.f_ack   = late_ack;
      late_ack    = 1'b0;
      bus.f_rdata = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    model();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((req_q.size() != 0 || rsp_q.size() != 0 || bus.t_req != 4'b0000 || bus.f_enable)
           && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("cycle_budget_expired", 32'(n), 32'(budget - 1));
    req_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 4; i++) pend[i] = 0;
    repeat (2) cycle();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_f_enable"}, 32'(bus.f_enable), 32'd0);
    check({pfx, "_f_write"}, 32'(bus.f_write), 32'd0);
    check({pfx, "_f_addr"}, bus.f_addr, 32'd0);
    check({pfx, "_f_wdata"}, bus.f_wdata, 32'd0);
    check({pfx, "_f_thread"}, 32'(bus.f_thread), 32'd0);
    check({pfx, "_t_ack"}, 32'(bus.t_ack), 32'd0);
    check({pfx, "_t_err"}, 32'(bus.t_err), 32'd0);
    check({pfx, "_t_rdata"}, bus.t_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0;
      set_thread(i, 1'b0, 32'h0, 32'h0);
      rd_val[i] = 32'h0;
    end
    bus.t_req   = '0;
    bus.f_ack   = 1'b0;
    bus.f_rdata = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    check_zero("reset");
    rst = 1'b0;
    cycle();

    // Single read: thread 2, ack sampled in the 3rd BUSY cycle
    set_thread(2, 1'b0, 32'h10, 32'h0);
    rd_val[2] = 32'd24;
    ack_delay = 3;
    push_req(2, 0);
    push_ack(2, 3);
    pend[2] = 1;
    model();
    run_until_idle(100);
    check("read_rdata_hold", bus.t_rdata, 32'd24);

    // Write: thread 0, data held stable throughout BUSY
    set_thread(0, 1'b1, 32'h40, 32'hDEADBEEF);
    rd_val[0] = 32'h1234_5678;
    ack_delay = 2;
    push_req(0, 0);
    push_ack(0, 2);
    pend[0] = 1;
    model();
    run_until_idle(100);

    // Fairness from reset: all four request, grants 0,1,2,3 every 3 cycles
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_thread(i, i[0], 32'h1000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
      rd_val[i] = 32'hC0DE_0000 + 32'(i);
    end
    ack_delay = 1;
    for (int i = 0; i < 4; i++) begin
      push_req(i, (i == 0) ? 0 : 3);
      push_ack(i, 1);
      pend[i] = 1;
    end
    model();
    run_until_idle(100);

    // Rotation: set last=1 with a lone thread-1 transaction, then 1 and 3 contend
    push_req(1, 0);
    push_ack(1, 1);
    pend[1] = 1;
    model();
    run_until_idle(100);
    for (int k = 0; k < 6; k++) begin
      push_req((k % 2 == 0) ? 3 : 1, (k == 0) ? 0 : 3);
      push_ack((k % 2 == 0) ? 3 : 1, 1);
    end
    pend[1] = 3;
    pend[3] = 3;
    model();
    run_until_idle(200);

    // Timeout: no ack, error after TMO cycles, late ack ignored, t_rdata kept
    ack_delay = 0;
    set_thread(2, 1'b0, 32'h2000, 32'h0);
    push_req(2, 0);
    push_err(2, TMO);
    pend[2] = 1;
    model();
    run_until_idle(100);
    late_ack = 1'b1;
    repeat (4) cycle();
    check("timeout_rdata_unchanged", bus.t_rdata, rd_val[1]);

    // Ack on the timeout cycle: ack wins, no error
    ack_delay = TMO;
    set_thread(3, 1'b0, 32'h3000, 32'h0);
    rd_val[3] = 32'h5A5A_5A5A;
    push_req(3, 0);
    push_ack(3, TMO);
    pend[3] = 1;
    model();
    run_until_idle(100);

    // Reset on the 2nd BUSY cycle drops the transaction
    ack_delay = 0;
    push_req(1, 0);
    pend[1] = 1;
    model();
    n = 0;
    while (!bus.f_enable && n < 20) begin
      cycle();
      n++;
    end
    check("rst_busy_grant_seen", 32'(bus.f_enable), 32'd1);
    cycle();
    rst = 1'b1;
    pend[1] = 0;
    model();
    cycle();
    check_zero("rst_busy");
    rst = 1'b0;
    late_ack = 1'b1;
    repeat (3) cycle();
    check_zero("rst_busy_late_ack");
    ack_delay = 1;
    rd_val[0] = 32'h0000_0A0A;
    rd_val[2] = 32'h0000_0B0B;
    set_thread(0, 1'b0, 32'h500, 32'h0);
    set_thread(2, 1'b1, 32'h600, 32'h77);
    push_req(0, 0);
    push_ack(0, 1);
    push_req(2, 3);
    push_ack(2, 1);
    pend[0] = 1;
    pend[2] = 1;
    model();
    run_until_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
